// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side transmitter with byte FIFO; `PS2_TX_BREAK_EN adds F0-prefixed break entries.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_brk,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] tx_count
);
`ifdef PS2_TX_BREAK_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int MX = CLK_DIV > GAP ? CLK_DIV : GAP;
  localparam int DW = $clog2(MX);
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  state_t st_q, st_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] idx_q, idx_d;
  logic [10:0] sh_q, sh_d;
  logic clk_q, clk_d, dat_q, dat_d;
  logic [7:0] tx_q, tx_d;
  logic push, pop;
  logic [W-1:0] head, wdata;
`ifdef PS2_TX_BREAK_EN
  logic pend_q, pend_d;
  logic [7:0] code_q, code_d;
  assign wdata = {in_brk, in_data};
`else
  logic unused_brk;
  assign unused_brk = in_brk;
  assign wdata = in_data;
`endif
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
  assign in_ready = cnt_q != CW'(FIFO_DEPTH);
  assign push = in_valid & in_ready;
  assign head = mem_q[rp_q];
  assign busy = cnt_q != '0 || st_q != S_IDLE;
  assign ps2_clk = clk_q;
  assign ps2_data = dat_q;
  assign tx_count = tx_q;
  // pop decision uses registered occupancy, so a fresh byte leaves one edge later
  always_comb begin
    st_d = st_q;
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    clk_d = clk_q;
    dat_d = dat_q;
    tx_d = tx_q;
    pop = 1'b0;
`ifdef PS2_TX_BREAK_EN
    pend_d = pend_q;
    code_d = code_q;
`endif
    case (st_q)
      S_IDLE: begin
        div_d = '0;
        if (cnt_q != '0) begin
          pop = 1'b1;
          st_d = S_HIGH;
          idx_d = '0;
          dat_d = 1'b0;
`ifdef PS2_TX_BREAK_EN
          sh_d = frame(head[8] ? 8'hF0 : head[7:0]);
          pend_d = head[8];
          code_d = head[7:0];
`else
          sh_d = frame(head);
`endif
        end
      end
      S_HIGH: if (div_q == DW'(CLK_DIV - 1)) begin
        st_d = S_LOW;
        div_d = '0;
        clk_d = 1'b0;
      end
      S_LOW: if (div_q == DW'(CLK_DIV - 1)) begin
        div_d = '0;
        clk_d = 1'b1;
        if (idx_q == 4'd10) begin
          st_d = S_GAP;
          tx_d = tx_q + 1'b1;
        end else begin
          st_d = S_HIGH;
          idx_d = idx_q + 1'b1;
          sh_d = sh_q >> 1;
          dat_d = sh_q[1];
        end
      end
      S_GAP: if (div_q == DW'(GAP - 1)) begin
        div_d = '0;
        st_d = S_IDLE;
`ifdef PS2_TX_BREAK_EN
        if (pend_q) begin
          st_d = S_HIGH;
          idx_d = '0;
          sh_d = frame(code_q);
          dat_d = 1'b0;
          pend_d = 1'b0;
        end
`endif
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= S_IDLE;
      div_q <= '0;
      idx_q <= '0;
      sh_q <= '1;
      clk_q <= 1'b1;
      dat_q <= 1'b1;
      tx_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      clk_q <= clk_d;
      dat_q <= dat_d;
      tx_q <= tx_d;
      wp_q <= push ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
`ifdef PS2_TX_BREAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      code_q <= '0;
    end else begin
      pend_q <= pend_d;
      code_q <= code_d;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: randomized self-checking bench; a line-level PS/2 receiver decodes frames for comparison.
module tb_ps2_kbd_tx;
  localparam int CD = 4;
  localparam int GP = 16;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_brk = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, ps2_clk, ps2_data, busy;
  logic [7:0] tx_count;
  int n_chk = 0, n_fail = 0, cyc = 0, glitch = 0, nb = 0;
  logic pc = 1'b1, pd = 1'b1;
  logic [10:0] fr;
  logic [10:0] rx_q[$];
  int t_first[$];

  ps2_kbd_tx #(.CLK_DIV(CD), .GAP(GP), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_brk(in_brk), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // receiver: sample data on each falling ps2_clk, flag data moving while clock is low
  always @(negedge clk) begin
    if (reset) begin
      nb = 0;
      pc = 1'b1;
      pd = 1'b1;
    end else begin
      if (!pc && !ps2_clk && ps2_data !== pd) glitch++;
      if (pc && !ps2_clk) begin
        if (nb == 0) t_first.push_back(cyc);
        fr[nb] = ps2_data;
        nb++;
        if (nb == 11) begin
          rx_q.push_back(fr);
          nb = 0;
        end
      end
      pc = ps2_clk;
      pd = ps2_data;
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic brk, output int edge_cyc);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    in_brk = brk;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 5000) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    @(negedge clk);
    while (busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= limit) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ps2_clk, ps2_data, in_ready, busy, tx_count} !== {3'b111, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: clk/data/ready/busy/cnt=%b%b%b%b/%0d, required 1110/0",
               ps2_clk, ps2_data, in_ready, busy, tx_count);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ps2_clk, ps2_data, in_ready, busy} !== 4'b1110) begin
      n_fail++;
      $display("FAIL post_reset: clk/data/ready/busy=%b%b%b%b, required 1110",
               ps2_clk, ps2_data, in_ready, busy);
    end
  endtask

  task automatic test_single();
    int n, t = 0, t_cnt = -1;
    rx_q.delete();
    t_first.delete();
    push_byte(8'h1C, 1'b0, n);
    @(negedge clk);
    n_chk++;
    if (ps2_data !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pre_start: ps2_data=%b at edge N, required 1", ps2_data);
    end
    @(negedge clk);
    n_chk++;
    if ({ps2_clk, ps2_data} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_start: clk/data=%b%b at edge N+1, required 10", ps2_clk, ps2_data);
    end
    while (t < 300 && t_cnt < 0) begin
      if (tx_count == 8'd1) t_cnt = cyc;
      else begin
        @(negedge clk);
        t++;
      end
    end
    n_chk++;
    if (t_cnt != n + 1 + 22 * CD) begin
      n_fail++;
      $display("FAIL single_txcount_edge: tx_count=1 at edge %0d, required %0d", t_cnt, n + 1 + 22 * CD);
    end
    wait_idle(500);
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== 11'h438) begin
      n_fail++;
      $display("FAIL single_frame: got %0d frames, first=%h, required 1 frame 438", rx_q.size(),
               rx_q.size() > 0 ? rx_q[0] : 11'h0);
    end
    n_chk++;
    if (t_first.size() < 1 || t_first[0] != n + 1 + CD) begin
      n_fail++;
      $display("FAIL single_first_fall: edge %0d, required %0d",
               t_first.size() > 0 ? t_first[0] : -1, n + 1 + CD);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[6];
    int n;
    for (int i = 0; i < 3; i++) e[i] = 8'($urandom);
    e[3] = 8'h1C;
    e[4] = 8'hF0;
    e[5] = 8'h1C;
    rx_q.delete();
    t_first.delete();
    glitch = 0;
    for (int i = 0; i < 6; i++) push_byte(e[i], 1'b0, n);
    wait_idle(2000);
    n_chk++;
    if (rx_q.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_count: %0d frames, required 6", rx_q.size());
    end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== mk(e[i])) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %h, required %h", i, rx_q[i], mk(e[i]));
      end
    end
    for (int i = 1; i < 6 && i < t_first.size(); i++) begin
      n_chk++;
      if (t_first[i] - t_first[i-1] != 22 * CD + GP + 1) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: %0d cycles, required %0d", i, t_first[i] - t_first[i-1], 22 * CD + GP + 1);
      end
    end
    n_chk++;
    if (glitch != 0) begin
      n_fail++;
      $display("FAIL b2b_data_while_low: %0d changes, required 0", glitch);
    end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] d[12];
    logic [7:0] b;
    int k = 0, acc = -1, t = 0;
    b = 8'($urandom);
    for (int i = 0; i < 12; i++) d[i] = b + 8'(i * 19);
    wait_idle(2000);
    rx_q.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_brk = 1'b0;
    while (k < 12 && t < 5000) begin
      in_data = d[k];
      if (in_ready) k++;
      else if (acc < 0) acc = k;
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (acc != 9) begin
      n_fail++;
      $display("FAIL fill_accepted: %0d before in_ready fell, required 9", acc);
    end
    wait_idle(3000);
    n_chk++;
    if (rx_q.size() != 12) begin
      n_fail++;
      $display("FAIL fill_count: %0d frames, required 12", rx_q.size());
    end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== mk(d[i])) begin
        n_fail++;
        $display("FAIL fill_order%0d: got %h, required %h", i, rx_q[i], mk(d[i]));
      end
    end
  endtask

  task automatic test_break();
    logic [7:0] tx0;
    int n;
    wait_idle(2000);
    rx_q.delete();
    tx0 = tx_count;
    push_byte(8'h1C, 1'b1, n);
    wait_idle(2000);
`ifdef PS2_TX_BREAK_EN
    n_chk++;
    if (rx_q.size() != 2 || rx_q[0] !== mk(8'hF0) || rx_q[1] !== mk(8'h1C) || rx_q[0][9] !== 1'b1) begin
      n_fail++;
      $display("FAIL break_frames: %0d frames, first=%h, required 2 frames %h %h", rx_q.size(),
               rx_q.size() > 0 ? rx_q[0] : 11'h0, mk(8'hF0), mk(8'h1C));
    end
    n_chk++;
    if (tx_count !== tx0 + 8'd2) begin
      n_fail++;
      $display("FAIL break_txcount: %0d, required %0d", tx_count, tx0 + 8'd2);
    end
`else
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== mk(8'h1C)) begin
      n_fail++;
      $display("FAIL nobreak_frames: %0d frames, first=%h, required 1 frame %h", rx_q.size(),
               rx_q.size() > 0 ? rx_q[0] : 11'h0, mk(8'h1C));
    end
    n_chk++;
    if (tx_count !== tx0 + 8'd1) begin
      n_fail++;
      $display("FAIL nobreak_txcount: %0d, required %0d", tx_count, tx0 + 8'd1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n, t = 0;
    wait_idle(2000);
    rx_q.delete();
    push_byte(8'h00, 1'b0, n);
    push_byte(8'($urandom), 1'b0, n);
    push_byte(8'($urandom), 1'b0, n);
    @(negedge clk);
    while (!(nb >= 4 && !ps2_clk) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (ps2_data !== 1'b0 || tx_count == 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_precond: data=%b cnt=%0d, required data 0 and cnt nonzero", ps2_data, tx_count);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({ps2_clk, ps2_data, in_ready, busy, tx_count} !== {3'b111, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL rstmid_immediate: clk/data/ready/busy/cnt=%b%b%b%b/%0d, required 1110/0",
               ps2_clk, ps2_data, in_ready, busy, tx_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    n_chk++;
    if (rx_q.size() != 0 || busy !== 1'b0 || tx_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_flushed: frames=%0d busy=%b cnt=%0d, required 0/0/0", rx_q.size(), busy, tx_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e[$];
    int n, bad = 0;
    rx_q.delete();
    glitch = 0;
    for (int i = 0; i < 255; i++) begin
      e.push_back(8'($urandom));
      push_byte(e[i], 1'b0, n);
    end
    wait_idle(40000);
    n_chk++;
    if (tx_count !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: tx_count=%0d, required 255", tx_count);
    end
    e.push_back(8'($urandom));
    push_byte(e[255], 1'b0, n);
    wait_idle(2000);
    n_chk++;
    if (tx_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: tx_count=%0d, required 0", tx_count);
    end
    for (int i = 0; i < 256 && i < rx_q.size(); i++) if (rx_q[i] !== mk(e[i])) bad++;
    n_chk++;
    if (rx_q.size() != 256 || bad != 0) begin
      n_fail++;
      $display("FAIL wrap_frames: %0d frames with %0d bad, required 256 with 0 bad", rx_q.size(), bad);
    end
    n_chk++;
    if (glitch != 0) begin
      n_fail++;
      $display("FAIL wrap_data_while_low: %0d changes, required 0", glitch);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_fill();
    test_break();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

- PS/2 device-side transmitter (keyboard emulator).
- Accepts scan-code bytes over a valid/ready port and buffers them in a small FIFO.
- Serialises each byte as a standard 11-bit PS/2 frame, generating both `ps2_clk` and `ps2_data`.
- Feeds the keyboard receiver path in simulation and on the board, and loops back for self-test.

## Interface
- `CLK_DIV`, 4: system clocks per PS/2 clock half-period (≥2).
- `GAP`, 16: idle system clocks between frames (≥1).
- `FIFO_DEPTH`, 8: byte FIFO entries, power of two.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: byte offered.
- `in_ready` out 1: FIFO not full. A byte is accepted on a `clk` edge where `in_valid & in_ready`.
- `in_data` in 8: scan code.
- `in_brk` in 1: break flag, stored with the byte. Used only under `PS2_TX_BREAK_EN`.
- `ps2_clk` out 1: PS/2 clock, idle 1.
- `ps2_data` out 1: PS/2 data, idle 1.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `tx_count` out 8: number of completed frames, wraps 255→0.

## Operation
- Frame format, in order:
  - start bit = 0
  - data[0..7], LSB first
  - odd parity = `~^data`
  - stop bit = 1
- FSM states: IDLE, HIGH, LOW, GAP. Internal signals: bit index 0..10, divider counter, shift register.
- IDLE: `ps2_clk=1`, `ps2_data=1`. On an edge where the FIFO is non-empty:
  - pop the head entry;
  - load the frame;
  - drive `ps2_data` = start bit;
  - enter HIGH with bit index 0.
- HIGH: `ps2_clk=1` for CLK_DIV cycles, `ps2_data` = current bit, then go to LOW.
- LOW: `ps2_clk=0` for CLK_DIV cycles, `ps2_data` held.
  - At the end of LOW with bit index <10: advance the index, drive the next bit, go to HIGH.
  - At the end of LOW with bit index 10: increment `tx_count`, drive `ps2_clk=1`, enter GAP.
- `ps2_data` changes only on entry to HIGH, never while `ps2_clk=0`. The receiver samples on the falling edge.
- GAP: lines idle for GAP cycles, then:
  - go to IDLE;
  - if a second frame is pending, start it instead (see Configuration).
- FIFO rules:
  - `in_ready = !full`.
  - A simultaneous push and pop keeps the count unchanged.
  - A pop uses the registered occupancy, so a byte pushed into an empty FIFO is popped on the following edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset, including mid-frame, takes effect immediately:
  - `ps2_clk=1`, `ps2_data=1`;
  - FSM to IDLE, FIFO flushed, `tx_count=0`;
  - `in_ready=1`, `busy=0`.
  - A truncated frame is not resumed.

## Timing
- Byte accepted at edge N, with the FIFO empty and FSM IDLE → `ps2_data` falls to 0 after edge N+1.
- First `ps2_clk` falling edge occurs CLK_DIV cycles after edge N+1.
- One frame = 22·CLK_DIV cycles, followed by GAP idle cycles.
- Frame-start to frame-start spacing, back-to-back = 22·CLK_DIV + GAP + 1 cycles.
- `tx_count` updates on the same edge that raises `ps2_clk` after the stop bit.

## Configuration
- Macro: `PS2_TX_BREAK_EN`.
- Defined:
  - Each FIFO entry is 9 bits, `{in_brk, in_data}`.
  - An entry with `in_brk=1` produces two frames from one pop: 0xF0, then the code.
  - A GAP separates the two frames.
  - `tx_count` increments twice.
- Undefined:
  - Entries are 8 bits and `in_brk` is ignored.
  - One frame per entry.

## Test plan
- CLK_DIV=4, push 0x1C:
  - `ps2_data` sequence is 0,0,0,1,1,1,0,0,0,0,1 on each falling `ps2_clk` (parity 0).
  - Frame lasts 88 cycles; `tx_count` goes 0→1.
- Loopback into the keyboard receiver, pushing 0x1C, 0xF0, 0x1C back-to-back:
  - the receiver decodes all three bytes with valid parity;
  - `ps2_data` is never seen changing while `ps2_clk=0`.
- FIFO_DEPTH=8, FSM idle, `in_valid` held high with 12 distinct bytes:
  - exactly 9 bytes are accepted before `in_ready` falls;
  - transmitted order matches push order.
- Assert `reset` mid-data-bit of a frame:
  - lines go 1/1 within the same cycle;
  - `busy=0`, `tx_count=0`;
  - pending bytes are not transmitted after release.
- With `PS2_TX_BREAK_EN` defined, push `in_brk=1`, code 0x1C:
  - frames 0xF0 (parity 1), then 0x1C;
  - `tx_count` +2.
- Same push without the macro: one frame 0x1C only.
- `tx_count` wrap: send 256 frames → `tx_count` returns to 0.
